seq_comp: RTL

Parametrised multi-cycle magnitude comparator, successor to the combinational 4-bit comparator. It accepts two WIDTH-bit operands on a start strobe and walks them MSB-first, CHUNK bits per cycle. It produces unsigned and two's-complement signed less/equal/greater flags together, with a busy/done handshake. It sits beside the datapath and is shared by any requester that can tolerate a fixed, known latency.

---
 rtl/seq_comp.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/seq_comp.sv
// seq_comp: multi-cycle magnitude comparator.
// Walks two WIDTH-bit operands MSB-first, CHUNK bits per cycle, and reports
// unsigned and two's-complement signed lt/eq/gt flags with a busy/done handshake.
// The signed track reuses the unsigned procedure on copies whose MSB is
// inverted, which maps two's-complement ordering onto unsigned ordering.
module seq_comp #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             u_lt,
  output logic             u_eq,
  output logic             u_gt,
  output logic             s_lt,
  output logic             s_eq,
  output logic             s_gt
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ua_sh, ub_sh, sa_sh, sb_sh;
  logic             u_dec, u_less, s_dec, s_less;

  logic [CHUNK-1:0] ua_top, ub_top, sa_top, sb_top;
  logic             u_dec_nx, u_less_nx, s_dec_nx, s_less_nx;
  logic             accept, last_step;

  assign ua_top = ua_sh[WIDTH-1 -: CHUNK];
  assign ub_top = ub_sh[WIDTH-1 -: CHUNK];
  assign sa_top = sa_sh[WIDTH-1 -: CHUNK];
  assign sb_top = sb_sh[WIDTH-1 -: CHUNK];

  // A start is honoured whenever no comparison is in flight (IDLE or FIN).
  assign accept    = start && (state != RUN);
  assign last_step = (state == RUN) && (cnt == LAST);

  assign busy = (state == RUN);
  assign done = (state == FIN);

  // Decision update for the current chunk: the first differing chunk wins and sticks.
  always_comb begin
    u_dec_nx  = u_dec | (ua_top != ub_top);
    u_less_nx = u_dec ? u_less : (ua_top < ub_top);
    s_dec_nx  = s_dec | (sa_top != sb_top);
    s_less_nx = s_dec ? s_less : (sa_top < sb_top);
  end

  // Control FSM and chunk counter; latency is fixed at N RUN cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          cnt   <= '0;
          state <= accept ? RUN : IDLE;
        end
        RUN: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= FIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Operand shift registers and sticky per-track decisions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ua_sh  <= '0;
      ub_sh  <= '0;
      sa_sh  <= '0;
      sb_sh  <= '0;
      u_dec  <= 1'b0;
      u_less <= 1'b0;
      s_dec  <= 1'b0;
      s_less <= 1'b0;
    end else if (accept) begin
      ua_sh  <= a;
      ub_sh  <= b;
      sa_sh  <= {~a[WIDTH-1], a[WIDTH-2:0]};
      sb_sh  <= {~b[WIDTH-1], b[WIDTH-2:0]};
      u_dec  <= 1'b0;
      u_less <= 1'b0;
      s_dec  <= 1'b0;
      s_less <= 1'b0;
    end else if (state == RUN) begin
      ua_sh  <= ua_sh << CHUNK;
      ub_sh  <= ub_sh << CHUNK;
      sa_sh  <= sa_sh << CHUNK;
      sb_sh  <= sb_sh << CHUNK;
      u_dec  <= u_dec_nx;
      u_less <= u_less_nx;
      s_dec  <= s_dec_nx;
      s_less <= s_less_nx;
    end
  end

  // Result flags load only on the final RUN edge and hold until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u_lt <= 1'b0;
      u_eq <= 1'b0;
      u_gt <= 1'b0;
      s_lt <= 1'b0;
      s_eq <= 1'b0;
      s_gt <= 1'b0;
    end else if (last_step) begin
      u_lt <= u_dec_nx & u_less_nx;
      u_eq <= ~u_dec_nx;
      u_gt <= u_dec_nx & ~u_less_nx;
      s_lt <= s_dec_nx & s_less_nx;
      s_eq <= ~s_dec_nx;
      s_gt <= s_dec_nx & ~s_less_nx;
    end
  end

endmodule
